// File: rtl/uart_cmd_parser_if.sv
// Command handshake bundle between the UART command parser (master) and
// the AXI master stage (slave).
interface uart_cmd_parser_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output cmd_ready
  );
endinterface

// File: rtl/uart_cmd_parser.sv
// UART command parser: assembles framed host commands from received bytes
// and presents one read/write command per frame over a valid/ready handshake.
// Frame: SYNC, opcode (01 write / 02 read), address MSB first, data MSB first
// (writes only), then an XOR checksum byte when CMD_CHECKSUM_EN is defined.
// Reports overrun, bad opcode, checksum and inter-byte timeout errors.
module uart_cmd_parser #(
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5,
  parameter int unsigned ADDR_BYTES = 4,
  parameter int unsigned DATA_BYTES = 4,
  parameter int unsigned TIMEOUT    = 100000
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               rx_done,
  input  logic [7:0]         rx_data,
  uart_cmd_parser_if.master  cmd,
  output logic               err_pulse,
  output logic [1:0]         err_code
);

  localparam int unsigned AW   = 8 * ADDR_BYTES;
  localparam int unsigned DW   = 8 * DATA_BYTES;
  localparam int unsigned MAXB = (ADDR_BYTES > DATA_BYTES) ? ADDR_BYTES : DATA_BYTES;
  localparam int unsigned CW   = (MAXB > 1) ? $clog2(MAXB) : 1;
  localparam int unsigned TW   = $clog2(TIMEOUT + 1);

  localparam logic [7:0] OP_WRITE = 8'h01;
  localparam logic [7:0] OP_READ  = 8'h02;

  localparam logic [1:0] ERR_OVERRUN = 2'd0;
  localparam logic [1:0] ERR_OPCODE  = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;
`ifdef CMD_CHECKSUM_EN
  localparam logic [1:0] ERR_CSUM    = 2'd2;
`endif

  typedef enum logic [2:0] {
    IDLE,
    OPCODE,
    ADDR,
    DATA,
`ifdef CMD_CHECKSUM_EN
    CSUM,
`endif
    ISSUE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic            write_q, write_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic            err_pulse_q, err_pulse_d;
  logic [1:0]      err_code_q, err_code_d;
`ifdef CMD_CHECKSUM_EN
  logic [7:0]      csum_q, csum_d;
`endif

  logic            tmo_active;

  // State and datapath registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      tcnt_q      <= '0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      err_pulse_q <= 1'b0;
      err_code_q  <= '0;
`ifdef CMD_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tcnt_q      <= tcnt_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      err_pulse_q <= err_pulse_d;
      err_code_q  <= err_code_d;
`ifdef CMD_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  // Next-state, byte assembly, error and timeout logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tcnt_d      = '0;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    err_pulse_d = 1'b0;
    err_code_d  = err_code_q;
`ifdef CMD_CHECKSUM_EN
    csum_d      = csum_q;
`endif
    tmo_active  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (rx_done && rx_data == SYNC_BYTE) begin
          state_d = OPCODE;
          cnt_d   = '0;
        end
      end

      OPCODE: begin
        tmo_active = 1'b1;
        if (rx_done) begin
          if (rx_data == OP_WRITE || rx_data == OP_READ) begin
            write_d = (rx_data == OP_WRITE);
            addr_d  = '0;
            wdata_d = '0;
            cnt_d   = '0;
            state_d = ADDR;
`ifdef CMD_CHECKSUM_EN
            csum_d  = rx_data;
`endif
          end else begin
            state_d     = IDLE;
            err_pulse_d = 1'b1;
            err_code_d  = ERR_OPCODE;
          end
        end
      end

      ADDR: begin
        tmo_active = 1'b1;
        if (rx_done) begin
          addr_d = (addr_q << 8) | AW'(rx_data);
`ifdef CMD_CHECKSUM_EN
          csum_d = csum_q ^ rx_data;
`endif
          if (cnt_q == CW'(ADDR_BYTES - 1)) begin
            cnt_d = '0;
            if (write_q) begin
              state_d = DATA;
            end else begin
`ifdef CMD_CHECKSUM_EN
              state_d = CSUM;
`else
              state_d = ISSUE;
`endif
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      DATA: begin
        tmo_active = 1'b1;
        if (rx_done) begin
          wdata_d = (wdata_q << 8) | DW'(rx_data);
`ifdef CMD_CHECKSUM_EN
          csum_d  = csum_q ^ rx_data;
`endif
          if (cnt_q == CW'(DATA_BYTES - 1)) begin
            cnt_d = '0;
`ifdef CMD_CHECKSUM_EN
            state_d = CSUM;
`else
            state_d = ISSUE;
`endif
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

`ifdef CMD_CHECKSUM_EN
      CSUM: begin
        tmo_active = 1'b1;
        if (rx_done) begin
          if (rx_data == csum_q) begin
            state_d = ISSUE;
          end else begin
            state_d     = IDLE;
            err_pulse_d = 1'b1;
            err_code_d  = ERR_CSUM;
          end
        end
      end
`endif

      ISSUE: begin
        // Bytes arriving while a command is pending are dropped, even SYNC.
        if (rx_done) begin
          err_pulse_d = 1'b1;
          err_code_d  = ERR_OVERRUN;
        end
        if (cmd.cmd_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    // An accepted byte clears the counter (default above); silence counts up.
    if (tmo_active && !rx_done) begin
      if (tcnt_q == TW'(TIMEOUT - 1)) begin
        state_d     = IDLE;
        err_pulse_d = 1'b1;
        err_code_d  = ERR_TIMEOUT;
      end else begin
        tcnt_d = tcnt_q + TW'(1);
      end
    end
  end

  assign cmd.cmd_valid = (state_q == ISSUE);
  assign cmd.cmd_write = write_q;
  assign cmd.cmd_addr  = addr_q;
  assign cmd.cmd_wdata = wdata_q;
  assign err_pulse     = err_pulse_q;
  assign err_code      = err_code_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed self-checking bench for uart_cmd_parser (small TIMEOUT override).
module tb_uart_cmd_parser;

  localparam int unsigned TMO = 50;

  logic       clk;
  logic       resetn;
  logic       rx_done;
  logic [7:0] rx_data;
  logic       err_pulse;
  logic [1:0] err_code;

  int checks;
  int failures;

  uart_cmd_parser_if #(.AW(32), .DW(32)) cmd_bus ();

  uart_cmd_parser #(
    .SYNC_BYTE (8'hA5),
    .ADDR_BYTES(4),
    .DATA_BYTES(4),
    .TIMEOUT   (TMO)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .rx_done  (rx_done),
    .rx_data  (rx_data),
    .cmd      (cmd_bus),
    .err_pulse(err_pulse),
    .err_code (err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Byte is presented for exactly one rising edge; returns on the following
  // falling edge, so outputs registered on that edge are visible on return.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_done = 1'b1;
    rx_data = b;
    @(negedge clk);
    rx_done = 1'b0;
    rx_data = 8'h00;
  endtask

  task automatic send_read_body(input logic [31:0] a);
    send_byte(a[31:24]);
    send_byte(a[23:16]);
    send_byte(a[15:8]);
    send_byte(a[7:0]);
  endtask

  task automatic send_read_frame(input logic [31:0] a, input logic [7:0] cs);
    send_byte(8'hA5);
    send_byte(8'h02);
    send_read_body(a);
`ifdef CMD_CHECKSUM_EN
    send_byte(cs);
`else
    if (cs == 8'hFF) $display("unused checksum byte");
`endif
  endtask

  task automatic handshake(input string tag);
    cmd_bus.cmd_ready = 1'b1;
    @(negedge clk);
    check({tag, "_valid_drop"}, 64'(cmd_bus.cmd_valid), 64'd0);
    cmd_bus.cmd_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic       stable;
    int         seen;
    checks            = 0;
    failures          = 0;
    resetn            = 1'b0;
    rx_done           = 1'b0;
    rx_data           = 8'h00;
    cmd_bus.cmd_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", 64'(cmd_bus.cmd_valid), 64'd0);
    check("rst_write", 64'(cmd_bus.cmd_write), 64'd0);
    check("rst_addr",  64'(cmd_bus.cmd_addr),  64'd0);
    check("rst_wdata", 64'(cmd_bus.cmd_wdata), 64'd0);
    check("rst_errp",  64'(err_pulse), 64'd0);
    check("rst_errc",  64'(err_code),  64'd0);
    resetn = 1'b1;
    @(negedge clk);

    // Write frame, ready held high
    cmd_bus.cmd_ready = 1'b1;
    send_byte(8'hA5); send_byte(8'h01);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
    send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE);
`ifdef CMD_CHECKSUM_EN
    send_byte(8'hEF);
    check("wr_not_early", 64'(cmd_bus.cmd_valid), 64'd0);
    send_byte(8'h33);
`else
    check("wr_not_early", 64'(cmd_bus.cmd_valid), 64'd0);
    send_byte(8'hEF);
`endif
    check("wr_valid", 64'(cmd_bus.cmd_valid), 64'd1);
    check("wr_write", 64'(cmd_bus.cmd_write), 64'd1);
    check("wr_addr",  64'(cmd_bus.cmd_addr),  64'h0000_1000);
    check("wr_wdata", 64'(cmd_bus.cmd_wdata), 64'hDEAD_BEEF);
    check("wr_noerr", 64'(err_pulse), 64'd0);
    @(negedge clk);
    check("wr_valid_drop", 64'(cmd_bus.cmd_valid), 64'd0);
    cmd_bus.cmd_ready = 1'b0;

    // Read frame, ready low for 20 cycles
    send_read_frame(32'h4000_0004, 8'h46);
    check("rd_valid", 64'(cmd_bus.cmd_valid), 64'd1);
    check("rd_write", 64'(cmd_bus.cmd_write), 64'd0);
    check("rd_addr",  64'(cmd_bus.cmd_addr),  64'h4000_0004);
    check("rd_wdata", 64'(cmd_bus.cmd_wdata), 64'd0);
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cmd_bus.cmd_valid !== 1'b1 || cmd_bus.cmd_addr !== 32'h4000_0004 ||
          cmd_bus.cmd_write !== 1'b0) stable = 1'b0;
    end
    check("rd_stable", 64'(stable), 64'd1);
    handshake("rd");

`ifdef CMD_CHECKSUM_EN
    // Bad checksum on a write frame
    send_byte(8'hA5); send_byte(8'h01);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
    send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
    send_byte(8'h34);
    check("cs_errp",  64'(err_pulse), 64'd1);
    check("cs_errc",  64'(err_code),  64'd2);
    check("cs_valid", 64'(cmd_bus.cmd_valid), 64'd0);
    @(negedge clk);
    check("cs_errp_one", 64'(err_pulse), 64'd0);
    send_read_frame(32'h1234_5678, 8'h02 ^ 8'h12 ^ 8'h34 ^ 8'h56 ^ 8'h78);
    check("cs_next_valid", 64'(cmd_bus.cmd_valid), 64'd1);
    check("cs_next_addr",  64'(cmd_bus.cmd_addr),  64'h1234_5678);
    handshake("cs_next");
`endif

    // Garbage in IDLE, then bad opcode
    send_byte(8'h55);
    check("junk_noerr", 64'(err_pulse), 64'd0);
    send_byte(8'hA5);
    send_byte(8'h07);
    check("op_errp", 64'(err_pulse), 64'd1);
    check("op_errc", 64'(err_code),  64'd1);
    @(negedge clk);
    check("op_errp_one", 64'(err_pulse), 64'd0);
    send_read_frame(32'h4000_0004, 8'h46);
    check("op_next_valid", 64'(cmd_bus.cmd_valid), 64'd1);

    // Overrun while pending: SYNC byte lost, command untouched
    send_byte(8'hA5);
    check("ovr_errp",  64'(err_pulse), 64'd1);
    check("ovr_errc",  64'(err_code),  64'd0);
    check("ovr_valid", 64'(cmd_bus.cmd_valid), 64'd1);
    check("ovr_addr",  64'(cmd_bus.cmd_addr),  64'h4000_0004);
    handshake("ovr");
    send_byte(8'h02);
    send_read_body(32'h4000_0004);
`ifdef CMD_CHECKSUM_EN
    send_byte(8'h46);
`endif
    @(negedge clk);
    check("ovr_sync_lost", 64'(cmd_bus.cmd_valid), 64'd0);

    // Byte arriving exactly in the timeout cycle is accepted
    send_byte(8'hA5);
    repeat (TMO - 2) @(negedge clk);
    send_byte(8'h02);
    check("tmo_edge_noerr", 64'(err_pulse), 64'd0);
    send_read_body(32'h0000_00AA);
`ifdef CMD_CHECKSUM_EN
    send_byte(8'h02 ^ 8'hAA);
`endif
    check("tmo_edge_valid", 64'(cmd_bus.cmd_valid), 64'd1);
    handshake("tmo_edge");

    // Timeout after A5 01 00
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
    seen = 0;
    for (int k = 1; k <= int'(TMO) + 5; k++) begin
      @(negedge clk);
      if (err_pulse === 1'b1) begin
        seen = k;
        break;
      end
    end
    check("tmo_cycles", 64'(seen), 64'(TMO));
    check("tmo_errc",   64'(err_code), 64'd3);
    send_read_frame(32'h0000_0BAD, 8'h02 ^ 8'h0B ^ 8'hAD);
    check("tmo_idle_valid", 64'(cmd_bus.cmd_valid), 64'd1);
    check("tmo_idle_addr",  64'(cmd_bus.cmd_addr),  64'h0000_0BAD);
    handshake("tmo_idle");

    // Reset mid-address
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h40); send_byte(8'h00);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    check("mrst_valid", 64'(cmd_bus.cmd_valid), 64'd0);
    check("mrst_addr",  64'(cmd_bus.cmd_addr),  64'd0);
    check("mrst_write", 64'(cmd_bus.cmd_write), 64'd0);
    check("mrst_errp",  64'(err_pulse), 64'd0);
    check("mrst_errc",  64'(err_code),  64'd0);
    @(negedge clk);
    resetn = 1'b1;
    send_byte(8'h00); send_byte(8'h04);
`ifdef CMD_CHECKSUM_EN
    send_byte(8'h46);
`endif
    @(negedge clk);
    check("mrst_discard_valid", 64'(cmd_bus.cmd_valid), 64'd0);
    check("mrst_discard_errp",  64'(err_pulse), 64'd0);
    send_read_frame(32'h4000_0004, 8'h46);
    check("mrst_after_valid", 64'(cmd_bus.cmd_valid), 64'd1);
    handshake("mrst_after");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
Downstream consumer of the UART receiver in the uart2axi bridge. Takes the receiver's single-cycle byte-done pulse and byte, assembles framed host commands and presents one read or write command per frame to the AXI master stage over a valid/ready handshake. Detects and reports malformed, corrupted, stalled and overrun frames.

Parameters:
SYNC_BYTE, 8'hA5, frame start marker
ADDR_BYTES, 4, address bytes per frame, MSB first; cmd_addr width = 8*ADDR_BYTES
DATA_BYTES, 4, write-data bytes per write frame, MSB first; cmd_wdata width = 8*DATA_BYTES
TIMEOUT, 100000, max clk cycles between bytes inside a frame

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
rx_done  in  1  one-cycle pulse: rx_data valid
rx_data  in  8  received byte
cmd_valid  out  1  command available
cmd_ready  in  1  AXI master accepts command
cmd_write  out  1  1 = write, 0 = read
cmd_addr  out  8*ADDR_BYTES  target address
cmd_wdata  out  8*DATA_BYTES  write data (zero for reads)
err_pulse  out  1  one-cycle error strobe
err_code  out  2  0 overrun, 1 bad opcode, 2 checksum, 3 timeout; held until next error

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-low (clk, resetn). Reset values: all outputs 0, state IDLE, counters/shift registers 0. Reset mid-frame discards the partial frame; no error reported.
- Frame: SYNC_BYTE, opcode (8'h01 write, 8'h02 read), ADDR_BYTES address, DATA_BYTES data (write only), checksum = XOR of all bytes after SYNC (CHECKSUM_EN only).
- Bytes are consumed only on cycles with rx_done=1; rx_data ignored otherwise.
- States: IDLE -> OPCODE on SYNC_BYTE; any other byte in IDLE silently ignored, no error. OPCODE: 01/02 -> ADDR, record cmd_write, clear csum accumulator then XOR opcode; other value -> IDLE, err code 1. ADDR: shift byte in, after ADDR_BYTES -> DATA (write) or CSUM/ISSUE (read). DATA: after DATA_BYTES -> CSUM/ISSUE. CSUM: byte == accumulator -> ISSUE, else -> IDLE, err code 2. ISSUE: cmd_valid=1.
- Byte counter sized for max(ADDR_BYTES, DATA_BYTES); cleared on each state entry.
- Latency: cmd_valid rises the cycle after rx_done of the final frame byte.
- Handshake: cmd_valid held, cmd_write/cmd_addr/cmd_wdata stable, until cmd_valid&cmd_ready; that cycle -> IDLE, cmd_valid 0 next cycle. cmd_ready while not valid ignored.
- Overrun: rx_done while in ISSUE (including the handshake cycle) drops the byte, err code 0; pending command unaffected. If that byte was SYNC_BYTE it is still lost.
- Timeout: counter cleared on every accepted byte and state entry; runs in OPCODE/ADDR/DATA/CSUM; reaching TIMEOUT -> IDLE, err code 3. Not active in IDLE or ISSUE. rx_done in the timeout cycle takes priority (byte accepted, no timeout).
- err_pulse is high exactly one cycle per error; err_code updated the same cycle.

Optional Feature:
CMD_CHECKSUM_EN. Defined: CSUM state present, checksum byte required and compared, mismatch -> err code 2. Undefined: no CSUM state, frame ends at last address/data byte, code 2 never produced, no accumulator logic.

Test Plan:
- CHECKSUM_EN, bytes A5 01 00 00 10 00 DE AD BE EF 33 -> cmd_valid next cycle, cmd_write=1, cmd_addr=32'h00001000, cmd_wdata=32'hDEADBEEF; cmd_ready held 1 -> valid drops after 1 cycle, no err.
- CHECKSUM_EN, A5 02 40 00 00 04 46 with cmd_ready=0 for 20 cycles -> cmd_valid held, cmd_write=0, cmd_addr=32'h40000004, wdata 0, stable until ready.
- Write frame with checksum 34 instead of 33 -> no cmd_valid, err_pulse 1 cycle, err_code=2; following good read frame accepted.
- 55 A5 07 -> 55 ignored, err_code=1 on 07; then A5 02 ... good frame accepted.
- A5 01 00 then TIMEOUT cycles silence -> err_code=3 exactly TIMEOUT cycles after last byte, state IDLE; byte during pending cmd_valid -> err_code=0, command unchanged; resetn low mid-address -> all outputs 0, no err.
